// File: rtl/rv32i_pkg.sv
// Shared RV32I decode definitions: opcode constants, ALU operation and
// immediate-format enums, and the per-opcode control decoder.
package rv32i_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  typedef enum logic [3:0] {
    ALU_ADD    = 4'd0,
    ALU_SUB    = 4'd1,
    ALU_SLL    = 4'd2,
    ALU_SLT    = 4'd3,
    ALU_SLTU   = 4'd4,
    ALU_XOR    = 4'd5,
    ALU_SRL    = 4'd6,
    ALU_SRA    = 4'd7,
    ALU_OR     = 4'd8,
    ALU_AND    = 4'd9,
    ALU_PASS_B = 4'd10
  } alu_op_e;

  typedef enum logic [2:0] {
    IMM_NONE = 3'd0,
    IMM_I    = 3'd1,
    IMM_S    = 3'd2,
    IMM_B    = 3'd3,
    IMM_U    = 3'd4,
    IMM_J    = 3'd5
  } imm_type_e;

  typedef struct packed {
    imm_type_e imm_type;
    alu_op_e   alu_op;
    logic      uses_rs1;
    logic      uses_rs2;
    logic      has_rd;
    logic      is_load;
    logic      illegal;
  } dec_ctrl_t;

  // Register-register and register-immediate arithmetic share funct3 coding;
  // only OP (not OP-IMM) may select SUB through instr[30].
  function automatic alu_op_e alu_from_funct(input logic [2:0] funct3,
                                             input logic       bit30,
                                             input logic       is_reg);
    alu_op_e op;
    case (funct3)
      3'b000:  op = (is_reg && bit30) ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = bit30 ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

  function automatic dec_ctrl_t decode_ctrl(input logic [31:0] instr);
    dec_ctrl_t c;
    c.imm_type = IMM_NONE;
    c.alu_op   = ALU_ADD;
    c.uses_rs1 = 1'b0;
    c.uses_rs2 = 1'b0;
    c.has_rd   = 1'b0;
    c.is_load  = 1'b0;
    c.illegal  = 1'b0;
    case (instr[6:0])
      OPC_OP: begin
        c.uses_rs1 = 1'b1;
        c.uses_rs2 = 1'b1;
        c.has_rd   = 1'b1;
        c.alu_op   = alu_from_funct(instr[14:12], instr[30], 1'b1);
      end
      OPC_OP_IMM: begin
        c.uses_rs1 = 1'b1;
        c.has_rd   = 1'b1;
        c.imm_type = IMM_I;
        c.alu_op   = alu_from_funct(instr[14:12], instr[30], 1'b0);
      end
      OPC_LOAD: begin
        c.uses_rs1 = 1'b1;
        c.has_rd   = 1'b1;
        c.imm_type = IMM_I;
        c.is_load  = 1'b1;
      end
      OPC_STORE: begin
        c.uses_rs1 = 1'b1;
        c.uses_rs2 = 1'b1;
        c.imm_type = IMM_S;
      end
      OPC_BRANCH: begin
        c.uses_rs1 = 1'b1;
        c.uses_rs2 = 1'b1;
        c.imm_type = IMM_B;
        case (instr[14:13])
          2'b10:   c.alu_op = ALU_SLT;
          2'b11:   c.alu_op = ALU_SLTU;
          default: c.alu_op = ALU_SUB;
        endcase
      end
      OPC_JAL: begin
        c.has_rd   = 1'b1;
        c.imm_type = IMM_J;
      end
      OPC_JALR: begin
        c.uses_rs1 = 1'b1;
        c.has_rd   = 1'b1;
        c.imm_type = IMM_I;
      end
      OPC_LUI: begin
        c.has_rd   = 1'b1;
        c.imm_type = IMM_U;
        c.alu_op   = ALU_PASS_B;
      end
      OPC_AUIPC: begin
        c.has_rd   = 1'b1;
        c.imm_type = IMM_U;
      end
      default: c.illegal = 1'b1;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/imm_gen.sv
// RV32I immediate generator: assembles the I/S/B/U/J immediate and
// sign-extends it to XLEN; IMM_NONE yields zero.
module imm_gen
  import rv32i_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr,
  input  imm_type_e       imm_type,
  output logic [XLEN-1:0] imm
);

  logic [31:0] imm32;
  logic        unused_opcode_bits;

  assign unused_opcode_bits = ^instr[6:0];

  always_comb begin
    imm32 = '0;
    case (imm_type)
      IMM_I:   imm32 = {{20{instr[31]}}, instr[31:20]};
      IMM_S:   imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_U:   imm32 = {instr[31:12], 12'b0};
      IMM_J:   imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm32 = '0;
    endcase
  end

  generate
    if (XLEN > 32) begin : g_wide
      assign imm = {{(XLEN-32){imm32[31]}}, imm32};
    end else begin : g_narrow
      assign imm = imm32[XLEN-1:0];
    end
  endgenerate

endmodule

// File: rtl/instruction_decode.sv
// RV32I decode stage with a one-entry EMPTY/FULL output register, load-use stall
// and flush. Define DECODE_WB_BYPASS_EN to forward same-cycle writeback data.
module instruction_decode
  import rv32i_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_if_valid,
  input  logic [31:0]           i_if_instr,
  input  logic [XLEN-1:0]       i_if_pc,
  output logic                  o_if_ready,
  output logic [REG_ADDR_W-1:0] o_rd_addr_1,
  output logic [REG_ADDR_W-1:0] o_rd_addr_2,
  input  logic [XLEN-1:0]       i_rd_data_1,
  input  logic [XLEN-1:0]       i_rd_data_2,
  input  logic                  i_wb_we,
  input  logic [REG_ADDR_W-1:0] i_wb_addr,
  input  logic [XLEN-1:0]       i_wb_data,
  input  logic                  i_flush,
  output logic                  o_ex_valid,
  input  logic                  i_ex_ready,
  output logic [XLEN-1:0]       o_ex_pc,
  output logic [XLEN-1:0]       o_ex_rs1_val,
  output logic [XLEN-1:0]       o_ex_rs2_val,
  output logic [XLEN-1:0]       o_ex_imm,
  output logic [REG_ADDR_W-1:0] o_ex_rd,
  output logic [3:0]            o_ex_alu_op,
  output logic                  o_ex_is_load,
  output logic                  o_ex_illegal
);

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

  state_e                state_q, state_d;
  logic [XLEN-1:0]       ex_pc_q, ex_pc_d;
  logic [XLEN-1:0]       ex_rs1_val_q, ex_rs1_val_d;
  logic [XLEN-1:0]       ex_rs2_val_q, ex_rs2_val_d;
  logic [XLEN-1:0]       ex_imm_q, ex_imm_d;
  logic [REG_ADDR_W-1:0] ex_rd_q, ex_rd_d;
  logic [3:0]            ex_alu_op_q, ex_alu_op_d;
  logic                  ex_is_load_q, ex_is_load_d;
  logic                  ex_illegal_q, ex_illegal_d;

  dec_ctrl_t             ctrl;
  logic [REG_ADDR_W-1:0] rs1_idx, rs2_idx, rd_idx;
  logic [XLEN-1:0]       imm;
  logic                  wb_match_1, wb_match_2;
  logic                  load_use, hazard, accept;
  logic [XLEN-1:0]       rs1_val, rs2_val;

  assign rs1_idx = REG_ADDR_W'(i_if_instr[19:15]);
  assign rs2_idx = REG_ADDR_W'(i_if_instr[24:20]);
  assign rd_idx  = REG_ADDR_W'(i_if_instr[11:7]);

  assign o_rd_addr_1 = rs1_idx;
  assign o_rd_addr_2 = rs2_idx;

  always_comb ctrl = decode_ctrl(i_if_instr);

  imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .instr    (i_if_instr),
    .imm_type (ctrl.imm_type),
    .imm      (imm)
  );

  // Only sources the instruction actually reads can create a dependency.
  assign wb_match_1 = i_wb_we && ctrl.uses_rs1 && (rs1_idx != '0) && (i_wb_addr == rs1_idx);
  assign wb_match_2 = i_wb_we && ctrl.uses_rs2 && (rs2_idx != '0) && (i_wb_addr == rs2_idx);

  assign load_use = (state_q == ST_FULL) && ex_is_load_q && (ex_rd_q != '0) &&
                    ((ctrl.uses_rs1 && (ex_rd_q == rs1_idx)) ||
                     (ctrl.uses_rs2 && (ex_rd_q == rs2_idx)));

`ifdef DECODE_WB_BYPASS_EN
  assign hazard = i_if_valid && load_use;

  always_comb begin
    rs1_val = '0;
    rs2_val = '0;
    if (ctrl.uses_rs1 && rs1_idx != '0) rs1_val = wb_match_1 ? i_wb_data : i_rd_data_1;
    if (ctrl.uses_rs2 && rs2_idx != '0) rs2_val = wb_match_2 ? i_wb_data : i_rd_data_2;
  end
`else
  logic unused_wb_data;
  assign unused_wb_data = ^i_wb_data;

  // Without forwarding, wait one cycle for the register file to absorb the write.
  assign hazard = i_if_valid && (load_use || wb_match_1 || wb_match_2);

  always_comb begin
    rs1_val = '0;
    rs2_val = '0;
    if (ctrl.uses_rs1 && rs1_idx != '0) rs1_val = i_rd_data_1;
    if (ctrl.uses_rs2 && rs2_idx != '0) rs2_val = i_rd_data_2;
  end
`endif

  assign o_if_ready = ((state_q == ST_EMPTY) || i_ex_ready) && !hazard && !i_flush;
  assign accept     = i_if_valid && o_if_ready;

  always_comb begin
    state_d      = state_q;
    ex_pc_d      = ex_pc_q;
    ex_rs1_val_d = ex_rs1_val_q;
    ex_rs2_val_d = ex_rs2_val_q;
    ex_imm_d     = ex_imm_q;
    ex_rd_d      = ex_rd_q;
    ex_alu_op_d  = ex_alu_op_q;
    ex_is_load_d = ex_is_load_q;
    ex_illegal_d = ex_illegal_q;

    if (i_flush) begin
      state_d = ST_EMPTY;
    end else if (accept) begin
      state_d = ST_FULL;
    end else if (i_ex_ready) begin
      state_d = ST_EMPTY;
    end

    if (accept) begin
      ex_pc_d      = i_if_pc;
      ex_rs1_val_d = rs1_val;
      ex_rs2_val_d = rs2_val;
      ex_imm_d     = imm;
      ex_rd_d      = ctrl.has_rd ? rd_idx : '0;
      ex_alu_op_d  = ctrl.alu_op;
      ex_is_load_d = ctrl.is_load;
      ex_illegal_d = ctrl.illegal;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_EMPTY;
      ex_pc_q      <= '0;
      ex_rs1_val_q <= '0;
      ex_rs2_val_q <= '0;
      ex_imm_q     <= '0;
      ex_rd_q      <= '0;
      ex_alu_op_q  <= '0;
      ex_is_load_q <= 1'b0;
      ex_illegal_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      ex_pc_q      <= ex_pc_d;
      ex_rs1_val_q <= ex_rs1_val_d;
      ex_rs2_val_q <= ex_rs2_val_d;
      ex_imm_q     <= ex_imm_d;
      ex_rd_q      <= ex_rd_d;
      ex_alu_op_q  <= ex_alu_op_d;
      ex_is_load_q <= ex_is_load_d;
      ex_illegal_q <= ex_illegal_d;
    end
  end

  assign o_ex_valid   = (state_q == ST_FULL);
  assign o_ex_pc      = ex_pc_q;
  assign o_ex_rs1_val = ex_rs1_val_q;
  assign o_ex_rs2_val = ex_rs2_val_q;
  assign o_ex_imm     = ex_imm_q;
  assign o_ex_rd      = ex_rd_q;
  assign o_ex_alu_op  = ex_alu_op_q;
  assign o_ex_is_load = ex_is_load_q;
  assign o_ex_illegal = ex_illegal_q;

endmodule

// File: tb/tb_instruction_decode.sv
// Scoreboard bench for instruction_decode: directed instructions push expected
// EX payloads; a negedge monitor pops and compares on every EX handshake.
module tb_instruction_decode;

  localparam int XLEN = 32;
  localparam int RW   = 5;
  localparam logic [3:0] A_ADD  = 4'd0;
  localparam logic [3:0] A_SUB  = 4'd1;
  localparam logic [3:0] A_PASS = 4'd10;

  logic            clk = 1'b0;
  logic            rst;
  logic            i_if_valid;
  logic [31:0]     i_if_instr;
  logic [XLEN-1:0] i_if_pc;
  logic            o_if_ready;
  logic [RW-1:0]   o_rd_addr_1, o_rd_addr_2;
  logic [XLEN-1:0] i_rd_data_1, i_rd_data_2;
  logic            i_wb_we;
  logic [RW-1:0]   i_wb_addr;
  logic [XLEN-1:0] i_wb_data;
  logic            i_flush;
  logic            o_ex_valid;
  logic            i_ex_ready;
  logic [XLEN-1:0] o_ex_pc, o_ex_rs1_val, o_ex_rs2_val, o_ex_imm;
  logic [RW-1:0]   o_ex_rd;
  logic [3:0]      o_ex_alu_op;
  logic            o_ex_is_load, o_ex_illegal;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic [3:0]  alu;
    logic        ld;
    logic        ill;
  } exp_t;

  typedef struct {
    logic [31:0] instr;
    exp_t        e;
  } vec_t;

  exp_t exp_q[$];
  exp_t mon_act, mon_exp;
  int   checks = 0;
  int   errors = 0;
  vec_t vecs[6];

  logic [XLEN-1:0] rf [32];

  always #5 clk = ~clk;

  instruction_decode #(.XLEN(XLEN), .REG_ADDR_W(RW)) dut (
    .clk          (clk),
    .rst          (rst),
    .i_if_valid   (i_if_valid),
    .i_if_instr   (i_if_instr),
    .i_if_pc      (i_if_pc),
    .o_if_ready   (o_if_ready),
    .o_rd_addr_1  (o_rd_addr_1),
    .o_rd_addr_2  (o_rd_addr_2),
    .i_rd_data_1  (i_rd_data_1),
    .i_rd_data_2  (i_rd_data_2),
    .i_wb_we      (i_wb_we),
    .i_wb_addr    (i_wb_addr),
    .i_wb_data    (i_wb_data),
    .i_flush      (i_flush),
    .o_ex_valid   (o_ex_valid),
    .i_ex_ready   (i_ex_ready),
    .o_ex_pc      (o_ex_pc),
    .o_ex_rs1_val (o_ex_rs1_val),
    .o_ex_rs2_val (o_ex_rs2_val),
    .o_ex_imm     (o_ex_imm),
    .o_ex_rd      (o_ex_rd),
    .o_ex_alu_op  (o_ex_alu_op),
    .o_ex_is_load (o_ex_is_load),
    .o_ex_illegal (o_ex_illegal)
  );

  // Register file model; x0 holds junk so the decoder must zero it itself.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) rf[i] <= '0;
      rf[0] <= 32'hDEAD_BEEF;
      rf[1] <= 32'd5;
      rf[2] <= 32'd7;
    end else if (i_wb_we) begin
      rf[i_wb_addr] <= i_wb_data;
    end
  end

  always_comb begin
    i_rd_data_1 = rf[o_rd_addr_1];
    i_rd_data_2 = rf[o_rd_addr_2];
  end

  // Monitor: an EX handshake completes at the next rising edge.
  always @(negedge clk) begin
    if (!rst && o_ex_valid && i_ex_ready) begin
      mon_act = '{o_ex_pc, o_ex_rs1_val, o_ex_rs2_val, o_ex_imm, o_ex_rd,
                  o_ex_alu_op, o_ex_is_load, o_ex_illegal};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_unexpected actual=%h required=<none>", mon_act);
      end else begin
        mon_exp = exp_q.pop_front();
        if (mon_act !== mon_exp) begin
          errors++;
          $display("FAIL ex_payload pc=%h actual=%h required=%h", o_ex_pc, mon_act, mon_exp);
        end else begin
          $display("txn pc=%h rs1=%h rs2=%h imm=%h rd=%0d alu=%0d ld=%0b ill=%0b",
                   o_ex_pc, o_ex_rs1_val, o_ex_rs2_val, o_ex_imm, o_ex_rd,
                   o_ex_alu_op, o_ex_is_load, o_ex_illegal);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] pc, input logic [31:0] rs1,
                              input logic [31:0] rs2, input logic [31:0] imm,
                              input logic [4:0] rd, input logic [3:0] alu,
                              input logic ld, input logic ill);
    exp_t e;
    e = '{pc, rs1, rs2, imm, rd, alu, ld, ill};
    return e;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0] = '{32'hFE20AE23, mk(32'h200, 5, 7, 32'hFFFF_FFFC, 0, A_ADD, 0, 0)};  // sw x2,-4(x1)
    vecs[1] = '{32'hFE208CE3, mk(32'h204, 5, 7, 32'hFFFF_FFF8, 0, A_SUB, 0, 0)};  // beq x1,x2,-8
    vecs[2] = '{32'h001000EF, mk(32'h208, 0, 0, 32'h0000_0800, 1, A_ADD, 0, 0)};  // jal x1,0x800
    vecs[3] = '{32'h123453B7, mk(32'h20C, 0, 0, 32'h1234_5000, 7, A_PASS, 0, 0)}; // lui x7,0x12345
    vecs[4] = '{32'h00200433, mk(32'h210, 0, 7, 32'h0, 8, A_ADD, 0, 0)};          // add x8,x0,x2
    vecs[5] = '{32'h0000037F, mk(32'h214, 0, 0, 32'h0, 0, A_ADD, 0, 1)};          // opcode 0x7F

    rst = 1'b1; i_if_valid = 1'b0; i_if_instr = '0; i_if_pc = '0;
    i_wb_we = 1'b0; i_wb_addr = '0; i_wb_data = '0; i_flush = 1'b0; i_ex_ready = 1'b0;
    step(); step();
    chk("reset_valid", 32'(o_ex_valid), 0);
    chk("reset_pc", o_ex_pc, 0);
    rst = 1'b0;

    // ADDI x1,x1,-1
    i_ex_ready = 1'b1; i_if_valid = 1'b1; i_if_instr = 32'hFFF08093; i_if_pc = 32'h100;
    exp_q.push_back(mk(32'h100, 5, 0, 32'hFFFF_FFFF, 1, A_ADD, 0, 0));
    #1;
    chk("addi_rd_addr_1", 32'(o_rd_addr_1), 1);
    chk("addi_if_ready", 32'(o_if_ready), 1);
    step();
    chk("addi_ex_valid", 32'(o_ex_valid), 1);
    chk("addi_imm", o_ex_imm, 32'hFFFF_FFFF);
    chk("addi_rs1", o_ex_rs1_val, 5);
    chk("addi_rd", 32'(o_ex_rd), 1);
    i_if_valid = 1'b0;
    step();
    chk("addi_drained", 32'(o_ex_valid), 0);

    // Backpressure: add held for three cycles, sub waits behind it
    i_ex_ready = 1'b0; i_if_valid = 1'b1; i_if_instr = 32'h002081B3; i_if_pc = 32'h104;
    exp_q.push_back(mk(32'h104, 5, 7, 0, 3, A_ADD, 0, 0));
    step();
    i_if_instr = 32'h40110233; i_if_pc = 32'h108;
    exp_q.push_back(mk(32'h108, 7, 5, 0, 4, A_SUB, 0, 0));
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("bp_if_ready", 32'(o_if_ready), 0);
      chk("bp_pc_hold", o_ex_pc, 32'h104);
      chk("bp_rs2_hold", o_ex_rs2_val, 7);
      step();
    end
    i_ex_ready = 1'b1;
    #1;
    chk("bp_release_ready", 32'(o_if_ready), 1);
    step();
    chk("bp_next_pc", o_ex_pc, 32'h108);
    i_if_valid = 1'b0;
    step();

    // Load-use: lw x2,0(x1) then add x3,x2,x2
    i_if_valid = 1'b1; i_if_instr = 32'h0000A103; i_if_pc = 32'h10C;
    exp_q.push_back(mk(32'h10C, 5, 0, 0, 2, A_ADD, 1, 0));
    step();
    i_if_instr = 32'h002101B3; i_if_pc = 32'h110;
    exp_q.push_back(mk(32'h110, 7, 7, 0, 3, A_ADD, 0, 0));
    #1;
    chk("lu_stall_ready", 32'(o_if_ready), 0);
    step();
    chk("lu_bubble_valid", 32'(o_ex_valid), 0);
    chk("lu_ready_after", 32'(o_if_ready), 1);
    step();
    chk("lu_add_valid", 32'(o_ex_valid), 1);
    chk("lu_add_pc", o_ex_pc, 32'h110);
    i_if_valid = 1'b0;
    step();

    // Writeback to x3 in the accept cycle of addi x5,x3,1
    i_wb_we = 1'b1; i_wb_addr = 5'd3; i_wb_data = 32'hA5A5_A5A5;
    i_if_valid = 1'b1; i_if_instr = 32'h00118293; i_if_pc = 32'h114;
    exp_q.push_back(mk(32'h114, 32'hA5A5_A5A5, 0, 1, 5, A_ADD, 0, 0));
    #1;
`ifdef DECODE_WB_BYPASS_EN
    chk("byp_ready", 32'(o_if_ready), 1);
    step();
    i_wb_we = 1'b0;
`else
    chk("byp_stall_ready", 32'(o_if_ready), 0);
    step();
    i_wb_we = 1'b0;
    #1;
    chk("byp_ready_after", 32'(o_if_ready), 1);
    step();
`endif
    chk("byp_rs1_val", o_ex_rs1_val, 32'hA5A5_A5A5);
    i_if_valid = 1'b0;
    step();

    // Flush while FULL with a new instruction offered
    i_ex_ready = 1'b0; i_if_valid = 1'b1; i_if_instr = 32'h00208313; i_if_pc = 32'h118;
    step();
    chk("fl_full", 32'(o_ex_valid), 1);
    i_if_instr = 32'h002081B3; i_if_pc = 32'h11C; i_flush = 1'b1;
    #1;
    chk("fl_if_ready", 32'(o_if_ready), 0);
    step();
    chk("fl_valid", 32'(o_ex_valid), 0);
    chk("fl_no_accept_pc", o_ex_pc, 32'h118);
    i_flush = 1'b0; i_if_valid = 1'b0; i_ex_ready = 1'b1;
    step();

    // Back-to-back formats, x0 source, and an illegal opcode last
    i_if_valid = 1'b1;
    for (int v = 0; v < 6; v++) begin
      i_if_instr = vecs[v].instr;
      i_if_pc    = vecs[v].e.pc;
      exp_q.push_back(vecs[v].e);
      step();
    end
    i_if_valid = 1'b0;
    chk("ill_flag", 32'(o_ex_illegal), 1);
    chk("ill_rd", 32'(o_ex_rd), 0);
    step();

    // Reset while FULL and stalled on a load-use
    i_ex_ready = 1'b0; i_if_valid = 1'b1; i_if_instr = 32'h0000A103; i_if_pc = 32'h300;
    step();
    chk("rst_pre_valid", 32'(o_ex_valid), 1);
    chk("rst_pre_load", 32'(o_ex_is_load), 1);
    i_if_instr = 32'h002101B3; i_if_pc = 32'h304;
    #1;
    chk("rst_pre_ready", 32'(o_if_ready), 0);
    rst = 1'b1;
    step();
    chk("rst_valid", 32'(o_ex_valid), 0);
    chk("rst_pc", o_ex_pc, 0);
    chk("rst_rs1", o_ex_rs1_val, 0);
    chk("rst_rd", 32'(o_ex_rd), 0);
    chk("rst_load", 32'(o_ex_is_load), 0);
    rst = 1'b0; i_if_valid = 1'b0;
    step();
    chk("rst_stays_empty", 32'(o_ex_valid), 0);

    chk("scoreboard_empty", 32'(exp_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
